// File: rtl/dff_write_arbiter.sv
// rtl/dff_write_arbiter.sv - arbitrates N requesters onto one shared W-bit register
//
// Ports:
//   clk      in   1     clock, all state changes on posedge
//   rst      in   1     synchronous reset, active-high
//   req      in   N     request vector, bit i = requester i
//   wdata    in   N*W   write data, requester i at [i*W +: W]
//   gnt      out  N     registered one-hot grant, one-cycle pulse
//   q        out  W     shared register value
//   q_src    out  SW    index of the requester that last wrote q
//   q_valid  out  1     set by the first write, cleared only by reset
//   busy     out  1     high while the FSM is in GRANT
//
// Build option: DFF_WRITE_ARBITER_FIXED_PRIO_EN selects fixed priority
// (lowest set index wins); otherwise round-robin from a rotating pointer.

module dff_write_arbiter #(
  parameter int N  = 4,
  parameter int W  = 8,
  parameter int SW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] wdata,
  output logic [N-1:0]   gnt,
  output logic [W-1:0]   q,
  output logic [SW-1:0]  q_src,
  output logic           q_valid,
  output logic           busy
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [N-1:0]    gnt_q, gnt_d;
  logic [W-1:0]    data_q, data_d;
  logic [SW-1:0]   src_q, src_d;
  logic            valid_q, valid_d;

  logic            win_found;
  logic [SW-1:0]   win_idx;
  logic [N-1:0]    win_oh;
  logic [W-1:0]    win_data;

`ifdef DFF_WRITE_ARBITER_FIXED_PRIO_EN

  // Lowest set index wins; scanning downward lets the lowest hit overwrite.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    win_oh    = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        win_found = 1'b1;
        win_idx   = SW'(i);
        win_oh    = N'(1) << i;
      end
    end
  end

`else

  logic [SW-1:0]   ptr_q, ptr_d;
  logic            hi_found;
  logic [SW-1:0]   hi_idx;
  logic            lo_found;
  logic [SW-1:0]   lo_idx;

  // Round-robin as two fixed-priority scans: the lowest request at or above
  // ptr wins; if there is none, every pending request sits below ptr, so the
  // lowest request overall is the wrapped winner.
  always_comb begin
    hi_found = 1'b0;
    hi_idx   = '0;
    lo_found = 1'b0;
    lo_idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        lo_found = 1'b1;
        lo_idx   = SW'(i);
        if (i >= int'(ptr_q)) begin
          hi_found = 1'b1;
          hi_idx   = SW'(i);
        end
      end
    end
    win_found = lo_found;
    win_idx   = hi_found ? hi_idx : lo_idx;
    win_oh    = '0;
    for (int i = 0; i < N; i++) begin
      if (win_found && (win_idx == SW'(i))) begin
        win_oh[i] = 1'b1;
      end
    end
  end

  // Pointer moves just past the winner, wrapping N-1 back to 0.
  always_comb begin
    ptr_d = ptr_q;
    if ((state_q == ST_IDLE) && win_found) begin
      ptr_d = (win_idx == SW'(N - 1)) ? '0 : win_idx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

`endif

  // One-hot data mux; only the winner's slice reaches the register.
  always_comb begin
    win_data = '0;
    for (int i = 0; i < N; i++) begin
      if (win_oh[i]) begin
        win_data = wdata[i*W +: W];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = '0;
    data_d  = data_q;
    src_d   = src_q;
    valid_d = valid_q;
    unique case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          state_d = ST_GRANT;
          gnt_d   = win_oh;
          data_d  = win_data;
          src_d   = win_idx;
          valid_d = 1'b1;
        end
      end
      // One-cycle hold-off so the granted requester can drop its request.
      ST_GRANT: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      data_q  <= '0;
      src_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      data_q  <= data_d;
      src_q   <= src_d;
      valid_q <= valid_d;
    end
  end

  assign gnt     = gnt_q;
  assign q       = data_q;
  assign q_src   = src_q;
  assign q_valid = valid_q;
  assign busy    = (state_q == ST_GRANT);

endmodule

// File: tb/tb_dff_write_arbiter.sv
// tb/tb_dff_write_arbiter.sv - directed self-checking bench for dff_write_arbiter

module tb_dff_write_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int SW = $clog2(N);

  logic           clk;
  logic           rst;
  logic [N-1:0]   req;
  logic [N*W-1:0] wdata;
  logic [N-1:0]   gnt;
  logic [W-1:0]   q;
  logic [SW-1:0]  q_src;
  logic           q_valid;
  logic           busy;

  int n_checks;
  int n_fail;

  dff_write_arbiter #(.N(N), .W(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .wdata   (wdata),
    .gnt     (gnt),
    .q       (q),
    .q_src   (q_src),
    .q_valid (q_valid),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    req = '0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    req   = 4'b1111;
    wdata = 32'hFFFF_FFFF;
    for (int c = 0; c < 2; c++) begin
      tick();
      n_checks++;
      if (gnt !== 4'b0000) begin
        n_fail++;
        $display("FAIL reset_gnt cyc%0d: got %b expected 0000", c, gnt);
      end
      n_checks++;
      if (q !== 8'h00) begin
        n_fail++;
        $display("FAIL reset_q cyc%0d: got %h expected 00", c, q);
      end
      n_checks++;
      if (q_src !== 2'd0) begin
        n_fail++;
        $display("FAIL reset_q_src cyc%0d: got %0d expected 0", c, q_src);
      end
      n_checks++;
      if (q_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_q_valid cyc%0d: got %b expected 0", c, q_valid);
      end
      n_checks++;
      if (busy !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_busy cyc%0d: got %b expected 0", c, busy);
      end
    end
    rst = 1'b0;
    req = '0;
  endtask

  task automatic test_single();
    reset_dut();
    tick();
    n_checks++;
    if (gnt !== 4'b0000 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_no_req: got gnt=%b busy=%b expected 0000/0", gnt, busy);
    end
    wdata = {8'h44, 8'hA5, 8'h22, 8'h11};
    req   = 4'b0100;
    tick();
    req = '0;
    n_checks++;
    if (gnt !== 4'b0100) begin
      n_fail++;
      $display("FAIL single_gnt: got %b expected 0100", gnt);
    end
    n_checks++;
    if (q !== 8'hA5) begin
      n_fail++;
      $display("FAIL single_q: got %h expected a5", q);
    end
    n_checks++;
    if (q_src !== 2'd2) begin
      n_fail++;
      $display("FAIL single_q_src: got %0d expected 2", q_src);
    end
    n_checks++;
    if (q_valid !== 1'b1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL single_valid_busy: got %b/%b expected 1/1", q_valid, busy);
    end
    tick();
    n_checks++;
    if (gnt !== 4'b0000 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL single_after: got gnt=%b busy=%b expected 0000/0", gnt, busy);
    end
    n_checks++;
    if (q !== 8'hA5 || q_src !== 2'd2 || q_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL single_hold: got q=%h src=%0d v=%b expected a5/2/1", q, q_src, q_valid);
    end
  endtask

  task automatic test_rotation();
    logic [3:0] exp_g [5];
    logic [7:0] exp_q [5];
    exp_g = '{4'b0010, 4'b0000, 4'b1000, 4'b0000, 4'b0010};
    exp_q = '{8'h11, 8'h11, 8'h33, 8'h33, 8'h11};
    reset_dut();
    wdata = {8'h33, 8'h99, 8'h11, 8'h88};
    req   = 4'b1010;
    for (int c = 0; c < 5; c++) begin
      tick();
      n_checks++;
      if (gnt !== exp_g[c]) begin
        n_fail++;
        $display("FAIL rotation_gnt cyc%0d: got %b expected %b", c, gnt, exp_g[c]);
      end
      n_checks++;
      if (q !== exp_q[c]) begin
        n_fail++;
        $display("FAIL rotation_q cyc%0d: got %h expected %h", c, q, exp_q[c]);
      end
    end
    req = '0;
  endtask

  task automatic test_fairness_wrap();
    logic [3:0] exp_g [10];
    logic [1:0] exp_s [10];
    exp_g = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100,
              4'b0000, 4'b1000, 4'b0000, 4'b0001, 4'b0000};
    exp_s = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd0, 2'd0};
    reset_dut();
    wdata = {8'hC3, 8'hC2, 8'hC1, 8'hC0};
    req   = 4'b1111;
    for (int c = 0; c < 10; c++) begin
      tick();
      n_checks++;
      if (gnt !== exp_g[c]) begin
        n_fail++;
        $display("FAIL fair_gnt cyc%0d: got %b expected %b", c, gnt, exp_g[c]);
      end
      n_checks++;
      if (q_src !== exp_s[c] || q !== (8'hC0 + 8'(exp_s[c]))) begin
        n_fail++;
        $display("FAIL fair_q cyc%0d: got src=%0d q=%h expected src=%0d q=%h",
                 c, q_src, q, exp_s[c], 8'hC0 + 8'(exp_s[c]));
      end
      n_checks++;
      if (busy !== (exp_g[c] != 4'b0000)) begin
        n_fail++;
        $display("FAIL fair_busy cyc%0d: got %b expected %b", c, busy, exp_g[c] != 4'b0000);
      end
    end
    req = '0;
  endtask

  task automatic test_reset_mid();
    reset_dut();
    wdata = {8'h44, 8'h33, 8'h22, 8'h11};
    req   = 4'b1111;
    tick();
    n_checks++;
    if (gnt !== 4'b0001 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_pre: got gnt=%b busy=%b expected 0001/1", gnt, busy);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++;
    if (gnt !== 4'b0000 || q !== 8'h00 || q_src !== 2'd0 || q_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_outputs: got gnt=%b q=%h src=%0d v=%b busy=%b expected all zero",
               gnt, q, q_src, q_valid, busy);
    end
    tick();
    n_checks++;
    if (gnt !== 4'b0001 || q !== 8'h11) begin
      n_fail++;
      $display("FAIL midrst_first_gnt: got gnt=%b q=%h expected 0001/11", gnt, q);
    end
    req = '0;
    tick();
  endtask

  task automatic test_back_to_back();
    reset_dut();
    wdata = {8'h44, 8'h5A, 8'h22, 8'h3C};
    req   = 4'b0001;
    tick();
    req = 4'b0100;
    n_checks++;
    if (gnt !== 4'b0001 || q !== 8'h3C) begin
      n_fail++;
      $display("FAIL b2b_first: got gnt=%b q=%h expected 0001/3c", gnt, q);
    end
    tick();
    n_checks++;
    if (gnt !== 4'b0000 || q !== 8'h3C || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_holdoff: got gnt=%b q=%h busy=%b expected 0000/3c/0", gnt, q, busy);
    end
    tick();
    req = '0;
    n_checks++;
    if (gnt !== 4'b0100 || q !== 8'h5A || q_src !== 2'd2) begin
      n_fail++;
      $display("FAIL b2b_second: got gnt=%b q=%h src=%0d expected 0100/5a/2", gnt, q, q_src);
    end
    tick();
  endtask

  task automatic test_prio();
    logic [3:0] exp_g [6];
`ifdef DFF_WRITE_ARBITER_FIXED_PRIO_EN
    exp_g = '{4'b0010, 4'b0000, 4'b0010, 4'b0000, 4'b0010, 4'b0000};
`else
    exp_g = '{4'b0010, 4'b0000, 4'b0100, 4'b0000, 4'b0010, 4'b0000};
`endif
    reset_dut();
    wdata = {8'h44, 8'h33, 8'h22, 8'h11};
    req   = 4'b0110;
    for (int c = 0; c < 6; c++) begin
      tick();
      n_checks++;
      if (gnt !== exp_g[c]) begin
        n_fail++;
        $display("FAIL prio_gnt cyc%0d: got %b expected %b", c, gnt, exp_g[c]);
      end
    end
    req = '0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    req      = '0;
    wdata    = '0;
    test_reset();
    test_single();
    test_rotation();
    test_fairness_wrap();
    test_reset_mid();
    test_back_to_back();
    test_prio();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
